// File: rtl/cpu_lsu.sv
// -----------------------------------------------------------------------------
// cpu_lsu -- load/store unit for the SELEN memory stage.
//
// Takes the load/store command held in the M-stage pipeline register and runs
// one Wishbone-classic bus cycle per command. Load data is aligned and
// sign/zero-extended. Store data is replicated across byte lanes, with the
// matching byte enables. The unit drives the hazard unit so that the pipeline
// holds until the access completes.
//
// Optional feature macro: CPU_LSU_TIMEOUT_EN
//   When defined, a bus-cycle watchdog aborts any cycle that sees no ack for
//   TIMEOUT clocks. The unit then completes with err_out=1.
//   When undefined, BUSY waits indefinitely and err_out is tied to 0.
//
// Ports
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   cmd_inM[1:0]     2'b11 load, 2'b10 store, 2'b0x no memory access
//   funct3M[2:0]     size: 000 byte, 001 half, 010 word; bit2 = zero-extend
//   addrM[31:0]      byte address
//   wdataM[31:0]     store data, right-justified
//   flashM           M stage flushed this cycle (suppresses launch)
//   rdata[31:0]      extended load result
//   stall_out        pipeline hold
//   ack_out          low while a bus cycle is outstanding
//   done_out         one-cycle completion pulse
//   misalign_out     completion was a misaligned access (valid with done_out)
//   err_out          completion was a watchdog timeout (valid with done_out)
//   wb_*_o           registered Wishbone master outputs
//   wb_dat_i         slave read data
//   wb_ack_i         slave acknowledge
// -----------------------------------------------------------------------------
module cpu_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cmd_inM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        flashM,
  output logic [31:0] rdata,
  output logic        stall_out,
  output logic        ack_out,
  output logic        done_out,
  output logic        misalign_out,
  output logic        err_out,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  logic        req;
  logic        misaligned;
  logic        launch;       // aligned request accepted in IDLE
  logic        mis_launch;   // misaligned request accepted in IDLE
  logic        complete;     // ack seen in BUSY
  logic        timeout_hit;  // watchdog expiry in BUSY without ack
  logic        tmo_expired;

  logic [3:0]  sel_next;
  logic [31:0] dat_next;

  // Access attributes captured at launch so that the M-stage inputs may
  // change freely while the bus cycle is outstanding.
  logic [2:0]  funct3_reg;
  logic [1:0]  addr_lo_reg;
  logic        misalign_reg;
  logic        err_reg;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sext;
  logic [31:0] load_ext;

  // Reset masks the request so that stall_out reads 0 while reset is high.
  assign req = cmd_inM[1] & ~flashM & ~reset;

  // Byte accesses are never misaligned. Sizes 10 and 11 are both handled as words.
  always_comb begin
    misaligned = 1'b0;
    case (funct3M[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addrM[0];
      default: misaligned = |addrM[1:0];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef CPU_LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt_reg;

  // The counter holds the number of BUSY cycles already elapsed. The watchdog
  // expires during the BUSY cycle that would bring the count to TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg <= 8'd0;
    end else if (launch) begin
      tmo_cnt_reg <= 8'd0;
    end else if (state_reg == BUSY) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end
  end

  assign tmo_expired = (tmo_cnt_reg == TMO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_expired    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    launch      = 1'b0;
    mis_launch  = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            mis_launch = 1'b1;
            state_next = DONE;
          end else begin
            launch     = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // An ack that arrives in the same cycle as watchdog expiry wins.
        if (wb_ack_i) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign stall_out    = ((state_reg == IDLE) & req) | (state_reg == BUSY);
  assign ack_out      = (state_reg != BUSY);
  assign done_out     = (state_reg == DONE);
  assign misalign_out = (state_reg == DONE) & misalign_reg;
`ifdef CPU_LSU_TIMEOUT_EN
  assign err_out      = (state_reg == DONE) & err_reg;
`else
  assign err_out      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Store lane construction
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_next = 4'b1111;
    dat_next = wdataM;
    case (funct3M[1:0])
      2'b00: begin
        sel_next = 4'b0001 << addrM[1:0];
        dat_next = {4{wdataM[7:0]}};
      end
      2'b01: begin
        sel_next = addrM[1] ? 4'b1100 : 4'b0011;
        dat_next = {2{wdataM[15:0]}};
      end
      default: begin
        sel_next = 4'b1111;
        dat_next = wdataM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension (uses the attributes latched at launch)
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_lane = wb_dat_i[7:0];
    case (addr_lo_reg)
      2'd0:    byte_lane = wb_dat_i[7:0];
      2'd1:    byte_lane = wb_dat_i[15:8];
      2'd2:    byte_lane = wb_dat_i[23:16];
      default: byte_lane = wb_dat_i[31:24];
    endcase
    half_lane = addr_lo_reg[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
    sext      = ~funct3_reg[2];
    load_ext  = wb_dat_i;
    case (funct3_reg[1:0])
      2'b00:   load_ext = {{24{sext & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{sext & half_lane[15]}}, half_lane};
      default: load_ext = wb_dat_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus outputs and completion status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= 32'd0;
      wb_sel_o     <= 4'd0;
      wb_dat_o     <= 32'd0;
      rdata        <= 32'd0;
      funct3_reg   <= 3'd0;
      addr_lo_reg  <= 2'd0;
      misalign_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else if (launch) begin
      wb_cyc_o     <= 1'b1;
      wb_stb_o     <= 1'b1;
      // A store is encoded as 2'b10, so the write enable is the inverted low bit.
      wb_we_o      <= ~cmd_inM[0];
      wb_adr_o     <= {addrM[31:2], 2'b00};
      wb_sel_o     <= sel_next;
      wb_dat_o     <= dat_next;
      funct3_reg   <= funct3M;
      addr_lo_reg  <= addrM[1:0];
      misalign_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else if (mis_launch) begin
      rdata        <= 32'd0;
      misalign_reg <= 1'b1;
      err_reg      <= 1'b0;
    end else if (complete) begin
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      // wb_we_o is still set here for a store, and a store completes with rdata=0.
      rdata        <= wb_we_o ? 32'd0 : load_ext;
    end else if (timeout_hit) begin
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      rdata        <= 32'd0;
      err_reg      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_lsu.sv
module tb_cpu_lsu;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd_inM;
  logic [2:0]  funct3M;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic        flashM;
  logic [31:0] rdata;
  logic        stall_out, ack_out, done_out, misalign_out, err_out;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  cpu_lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_inM(cmd_inM), .funct3M(funct3M),
    .addrM(addrM), .wdataM(wdataM), .flashM(flashM), .rdata(rdata),
    .stall_out(stall_out), .ack_out(ack_out), .done_out(done_out),
    .misalign_out(misalign_out), .err_out(err_out),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;   // slave read data
    int          waits;   // BUSY cycles without ack before the ack cycle
    logic        mis;
    logic [3:0]  sel;
    logic [31:0] dat;     // checked for stores only
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] cmd, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] sdata, input int waits, input logic mis,
                              input logic [3:0] sel, input logic [31:0] dat,
                              input logic [31:0] rd);
    mk.cmd = cmd; mk.f3 = f3; mk.addr = addr; mk.wdata = wdata; mk.sdata = sdata;
    mk.waits = waits; mk.mis = mis; mk.sel = sel; mk.dat = dat; mk.rd = rd;
  endfunction

  localparam logic [1:0] LD = 2'b11;
  localparam logic [1:0] ST = 2'b10;

  vec_t vecs[13];

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    cmd_inM = v.cmd; funct3M = v.f3; addrM = v.addr; wdataM = v.wdata;
    flashM = 1'b0; wb_dat_i = v.sdata;
    #1 check("stall_t0", {31'd0, stall_out}, 32'd1);
    @(posedge clk); @(negedge clk);
    // M-stage inputs change while the access is in flight and must be ignored.
    cmd_inM = 2'b00; addrM = 32'hFFFF_FFFF; funct3M = 3'b011; wdataM = 32'h0;
    #1;
    if (v.mis) begin
      check("mis_done", {31'd0, done_out}, 32'd1);
      check("mis_flag", {31'd0, misalign_out}, 32'd1);
      check("mis_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("mis_stall", {31'd0, stall_out}, 32'd0);
      check("mis_rdata", rdata, 32'd0);
    end else begin
      check("adr", wb_adr_o, {v.addr[31:2], 2'b00});
      check("sel", {28'd0, wb_sel_o}, {28'd0, v.sel});
      check("we", {31'd0, wb_we_o}, {31'd0, v.cmd == ST});
      check("stb", {31'd0, wb_stb_o}, 32'd1);
      if (v.cmd == ST) check("dat", wb_dat_o, v.dat);
      for (int w = 0; w <= v.waits; w++) begin
        check("busy_flags", {29'd0, wb_cyc_o, ack_out, stall_out}, 32'b101);
        if (w == v.waits) wb_ack_i = 1'b1;
        @(posedge clk); @(negedge clk);
        wb_ack_i = 1'b0;
        #1;
      end
      check("done", {31'd0, done_out}, 32'd1);
      check("done_stall_ack", {30'd0, stall_out, ack_out}, 32'b01);
      check("done_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("done_mis_err", {30'd0, misalign_out, err_out}, 32'd0);
      check("rdata", rdata, v.rd);
    end
    @(posedge clk); @(negedge clk);
    #1 check("idle_done", {31'd0, done_out}, 32'd0);
    check("rdata_hold", rdata, v.rd);
    $display("txn %0d: cmd=%b f3=%b addr=0x%08h rdata=0x%08h", idx, v.cmd, v.f3, v.addr, rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int busy_cnt;
    int low_cnt;

    vecs[0]  = mk(LD, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk(LD, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80);
    vecs[2]  = mk(ST, 3'b001, 32'h206, 32'h1234ABCD, 32'h0,        3, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0);
    vecs[3]  = mk(LD, 3'b100, 32'h103, 32'h0,        32'h80112233, 1, 1'b0, 4'b1000, 32'h0,        32'h00000080);
    vecs[4]  = mk(ST, 3'b000, 32'h201, 32'h000000A5, 32'h0,        1, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    vecs[5]  = mk(LD, 3'b101, 32'h102, 32'h0,        32'h80112233, 2, 1'b0, 4'b1100, 32'h0,        32'h00008011);
    vecs[6]  = mk(ST, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0);
    vecs[7]  = mk(LD, 3'b001, 32'h100, 32'h0,        32'h1234F00D, 0, 1'b0, 4'b0011, 32'h0,        32'hFFFFF00D);
    vecs[8]  = mk(LD, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    vecs[9]  = mk(LD, 3'b000, 32'h101, 32'h0,        32'h0000C300, 0, 1'b0, 4'b0010, 32'h0,        32'hFFFFFFC3);
    vecs[10] = mk(ST, 3'b010, 32'h302, 32'h11111111, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(LD, 3'b001, 32'h102, 32'h0,        32'h7FFF0000, 0, 1'b0, 4'b1100, 32'h0,        32'h00007FFF);
    vecs[12] = mk(LD, 3'b001, 32'h103, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);

    // Reset state, with a load request present to show that req is masked.
    reset = 1'b1; cmd_inM = LD; funct3M = 3'b010; addrM = 32'h100; wdataM = 32'h0;
    flashM = 1'b0; wb_dat_i = 32'h0; wb_ack_i = 1'b0;
    #12;
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_ack", {31'd0, ack_out}, 32'd1);
    check("rst_bus_ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_sel_dat", {28'd0, wb_sel_o} | wb_dat_o, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_flags", {29'd0, done_out, misalign_out, err_out}, 32'd0);
    cmd_inM = 2'b00;
    @(negedge clk) reset = 1'b0;

    // Flushed request does not launch.
    @(negedge clk);
    cmd_inM = LD; funct3M = 3'b010; addrM = 32'h40; flashM = 1'b1;
    #1 check("flush_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); @(negedge clk);
    #1 check("flush_no_cyc", {30'd0, wb_cyc_o, done_out}, 32'd0);
    cmd_inM = 2'b00; flashM = 1'b0;
    $display("txn flush: flushed load suppressed, cyc=%b", wb_cyc_o);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Ack outside BUSY is ignored.
    @(negedge clk) wb_ack_i = 1'b1;
    @(posedge clk); @(negedge clk);
    wb_ack_i = 1'b0;
    #1 check("stray_ack", {30'd0, done_out, ~ack_out}, 32'd0);
    $display("txn stray_ack: done=%b", done_out);

    // Back-to-back: command held; no launch from DONE, relaunch from IDLE.
    @(negedge clk);
    cmd_inM = LD; funct3M = 3'b010; addrM = 32'h500; wb_dat_i = 32'h11112222;
    #1 check("b2b_t0_stall", {31'd0, stall_out}, 32'd1);
    @(posedge clk); @(negedge clk);
    wb_ack_i = 1'b1;
    @(posedge clk); @(negedge clk);
    wb_ack_i = 1'b0;
    #1 check("b2b_done", {29'd0, done_out, stall_out, wb_cyc_o}, 32'b100);
    check("b2b_rdata1", rdata, 32'h11112222);
    @(posedge clk); @(negedge clk);
    #1 check("b2b_relaunch", {30'd0, stall_out, wb_cyc_o}, 32'b10);
    wb_dat_i = 32'h33334444;
    @(posedge clk); @(negedge clk);
    cmd_inM = 2'b00;
    #1 check("b2b_cyc2", {31'd0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1'b1;
    @(posedge clk); @(negedge clk);
    wb_ack_i = 1'b0;
    #1 check("b2b_rdata2", rdata, 32'h33334444);
    $display("txn b2b: rdata=0x%08h", rdata);

    // flashM during BUSY does not abandon the bus cycle.
    @(negedge clk);
    cmd_inM = ST; funct3M = 3'b010; addrM = 32'h600; wdataM = 32'h5A5A0000;
    @(posedge clk); @(negedge clk);
    cmd_inM = 2'b00; flashM = 1'b1;
    @(posedge clk); @(negedge clk);
    #1 check("flush_busy_cyc", {31'd0, wb_cyc_o}, 32'd1);
    flashM = 1'b0; wb_ack_i = 1'b1;
    @(posedge clk); @(negedge clk);
    wb_ack_i = 1'b0;
    #1 check("flush_busy_done", {31'd0, done_out}, 32'd1);
    check("store_rdata_zero", rdata, 32'd0);
    $display("txn flush_busy: done=%b", done_out);

    // Reset mid-BUSY drops the bus cycle without a clock edge.
    @(negedge clk);
    cmd_inM = LD; funct3M = 3'b010; addrM = 32'h700; wb_dat_i = 32'h99999999;
    @(posedge clk); @(negedge clk);
    cmd_inM = 2'b00;
    #1 check("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #1 reset = 1'b1;
    #1 check("async_rst_bus", {29'd0, wb_cyc_o, wb_stb_o, ~ack_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0; wb_ack_i = 1'b1;
    @(posedge clk); @(negedge clk);
    wb_ack_i = 1'b0;
    #1 check("post_rst_ack_ignored", {29'd0, done_out, wb_cyc_o, stall_out}, 32'd0);
    check("post_rst_rdata", rdata, 32'd0);
    $display("txn reset_busy: cyc=%b done=%b", wb_cyc_o, done_out);

    // Unacknowledged bus cycle.
    @(negedge clk);
    cmd_inM = LD; funct3M = 3'b010; addrM = 32'h800; wb_dat_i = 32'h12345678;
    @(posedge clk); @(negedge clk);
    cmd_inM = 2'b00;
`ifdef CPU_LSU_TIMEOUT_EN
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!wb_cyc_o) break;
      busy_cnt++;
      @(posedge clk); @(negedge clk);
    end
    check("tmo_busy_cycles", busy_cnt, TB_TIMEOUT);
    check("tmo_done_err", {30'd0, done_out, err_out}, 32'b11);
    check("tmo_rdata", rdata, 32'd0);
    $display("txn timeout: busy_cycles=%0d err=%b", busy_cnt, err_out);
`else
    low_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (!wb_cyc_o) low_cnt++;
      @(posedge clk); @(negedge clk);
    end
    check("no_tmo_cyc_held", low_cnt, 0);
    wb_ack_i = 1'b1;
    @(posedge clk); @(negedge clk);
    wb_ack_i = 1'b0;
    #1 check("no_tmo_done", {30'd0, done_out, err_out}, 32'b10);
    check("no_tmo_rdata", rdata, 32'h12345678);
    $display("txn no_timeout: cyc_low_cycles=%0d", low_cnt);
    busy_cnt = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
